// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bus between the core and the data-memory controller
// req_*: one request per cycle when req_valid=1 (no back-pressure).
// rsp_*: one in-order response strobe per accepted request.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed data memory with sized loads/stores, error detection and fixed-latency responses
// clk/reset   : rising-edge clock, asynchronous active-low reset
// bus         : request/response interface (slave side)
// clr_err     : synchronous clear of err_sticky (a new error response wins)
// err_sticky  : latched on any error response
// acc_count   : accepted-request counter, wraps at 0xFFFF
module data_mem_ctrl #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int OUT_REG = 0
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_ctrl_if.slave  bus,
  input  logic            clr_err,
  output logic            err_sticky,
  output logic [15:0]     acc_count
);
  localparam int B  = DATA_W / 8;
  localparam int LB = $clog2(B);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [LB-1:0]     lane, lane1;
  logic [ADDR_W-1:0] widx;
  logic              oor, rsv, misal, err, wr, err_set;
  logic [B-1:0]      be;
  logic [DATA_W-1:0] wd, rd1, sh, ld, r_data;
  logic              v1, err1, we1, uns1, s8, s16, r_valid, r_err;
  logic [1:0]        size1;
  always_comb begin
    lane  = bus.req_addr[LB-1:0];
    widx  = bus.req_addr >> LB;
    oor   = widx >= ADDR_W'(DEPTH);
    rsv   = bus.req_size == 2'b11;
    misal = (bus.req_size == 2'b01 && lane[0]) || (bus.req_size == 2'b10 && lane != '0);
    err   = oor | rsv | misal;
    wr    = bus.req_valid & bus.req_we & ~err;
    be    = bus.req_size == 2'b00 ? B'(1) << lane : bus.req_size == 2'b01 ? B'(3) << lane : '1;
    wd    = bus.req_size == 2'b00 ? {B{bus.req_wdata[7:0]}} :
            bus.req_size == 2'b01 ? {(B/2){bus.req_wdata[15:0]}} : bus.req_wdata;
  end
  // Write and read happen on the accept edge, so a load issued the cycle after a
  // store already sees the stored word: no forwarding path is needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < B; i++)
      if (wr && be[i]) mem[widx[AW-1:0]][8*i +: 8] <= wd[8*i +: 8];
    if (bus.req_valid) rd1 <= mem[widx[AW-1:0]];
  end
`ifndef SYNTHESIS
  always @(posedge clk)
    if (reset && wr) $display("data_mem_ctrl store: addr=%h data=%h be=%b", bus.req_addr, wd, be);
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v1         <= 1'b0;
      err1       <= 1'b0;
      we1        <= 1'b0;
      uns1       <= 1'b0;
      size1      <= '0;
      lane1      <= '0;
      acc_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      v1         <= bus.req_valid;
      err1       <= err;
      we1        <= bus.req_we;
      uns1       <= bus.req_unsigned;
      size1      <= bus.req_size;
      lane1      <= lane;
      acc_count  <= acc_count + 16'(bus.req_valid);
      err_sticky <= err_set | (err_sticky & ~clr_err);
    end
  always_comb begin
    sh      = rd1 >> {lane1, 3'b000};
    s8      = sh[7] & ~uns1;
    s16     = sh[15] & ~uns1;
    ld      = size1 == 2'b00 ? DATA_W'(sh[7:0]) | ({DATA_W{s8}} & ~DATA_W'(8'hff)) :
              size1 == 2'b01 ? DATA_W'(sh[15:0]) | ({DATA_W{s16}} & ~DATA_W'(16'hffff)) : sh;
    r_valid = v1;
    r_err   = v1 & err1;
    r_data  = (v1 & ~we1 & ~err1) ? ld : '0;
  end
  // err_sticky is updated on the same edge that presents the error response.
  if (OUT_REG != 0) begin : g_out
    logic              v2, e2;
    logic [DATA_W-1:0] d2;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        v2 <= 1'b0;
        e2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= r_valid;
        e2 <= r_err;
        d2 <= r_data;
      end
    assign bus.rsp_valid = v2;
    assign bus.rsp_err   = e2;
    assign bus.rsp_rdata = d2;
    assign err_set       = r_err;
  end else begin : g_comb
    assign bus.rsp_valid = r_valid;
    assign bus.rsp_err   = r_err;
    assign bus.rsp_rdata = r_data;
    assign err_set       = bus.req_valid & err;
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl with OUT_REG=0 and OUT_REG=1 instances
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr_err = 1'b0;
  logic        es0, es1;
  logic [15:0] ac0, ac1;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_acc = '0;
  always #5 clk = ~clk;
  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) b0 ();
  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) b1 ();
  data_mem_ctrl #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .OUT_REG(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0), .clr_err(clr_err), .err_sticky(es0), .acc_count(ac0)
  );
  data_mem_ctrl #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .OUT_REG(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .clr_err(clr_err), .err_sticky(es1), .acc_count(ac1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    b0.req_valid = v; b0.req_we = we; b0.req_size = sz; b0.req_unsigned = uns; b0.req_addr = a; b0.req_wdata = wd;
    b1.req_valid = v; b1.req_we = we; b1.req_size = sz; b1.req_unsigned = uns; b1.req_addr = a; b1.req_wdata = wd;
  endtask
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    drive(1'b1, we, sz, uns, a, wd);
    exp_acc++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(b0.rsp_valid), 32'h0);
    chk("rst_rdata", b0.rsp_rdata, 32'h0);
    chk("rst_err", 32'(b0.rsp_err), 32'h0);
    chk("rst_sticky", 32'(es0), 32'h0);
    chk("rst_acc", 32'(ac0), 32'h0);
    reset = 1'b1;
    idle();
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("st_valid", 32'(b0.rsp_valid), 32'h1);
    chk("st_rdata", b0.rsp_rdata, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("raw_valid", 32'(b0.rsp_valid), 32'h1);
    chk("raw_rdata", b0.rsp_rdata, 32'hDEADBEEF);
    chk("raw_err", 32'(b0.rsp_err), 32'h0);
    idle();
    chk("idle_valid", 32'(b0.rsp_valid), 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("lb_signed", b0.rsp_rdata, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    chk("lb_unsigned", b0.rsp_rdata, 32'h00000080);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_merged", b0.rsp_rdata, 32'h80ADBEEF);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("lh_signed", b0.rsp_rdata, 32'hFFFF80AD);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    chk("lh_unsigned", b0.rsp_rdata, 32'h0000BEEF);
    issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("lb_lane1", b0.rsp_rdata, 32'hFFFFFFBE);
    issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    chk("mis_half_err", 32'(b0.rsp_err), 32'h1);
    chk("mis_half_rdata", b0.rsp_rdata, 32'h0);
    chk("mis_half_sticky", 32'(es0), 32'h1);
    issue(1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678);
    chk("mis_store_err", 32'(b0.rsp_err), 32'h1);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("mis_store_nowrite", b0.rsp_rdata, 32'h80ADBEEF);
    chk("good_err", 32'(b0.rsp_err), 32'h0);
    chk("sticky_held", 32'(es0), 32'h1);
    clr_err = 1'b1;
    idle();
    clr_err = 1'b0;
    chk("sticky_clr", 32'(es0), 32'h0);
    clr_err = 1'b1;
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    clr_err = 1'b0;
    chk("sticky_set_wins", 32'(es0), 32'h1);
    clr_err = 1'b1;
    idle();
    clr_err = 1'b0;
    chk("sticky_clr2", 32'(es0), 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D);
    chk("top_store_err", 32'(b0.rsp_err), 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
    chk("top_load", b0.rsp_rdata, 32'hCAFEF00D);
    issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    chk("oor_err", 32'(b0.rsp_err), 32'h1);
    chk("oor_rdata", b0.rsp_rdata, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    chk("rsv_err", 32'(b0.rsp_err), 32'h1);
    chk("acc_count", 32'(ac0), 32'(exp_acc));
    chk("acc_count_r1", 32'(ac1), 32'(exp_acc));
    idle();
    idle();
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("or_lat_r0", 32'(b1.rsp_valid), 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    chk("or_valid1", 32'(b1.rsp_valid), 32'h1);
    chk("or_data1", b1.rsp_rdata, 32'h80ADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
    chk("or_valid2", 32'(b1.rsp_valid), 32'h1);
    chk("or_data2", b1.rsp_rdata, 32'h00000080);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    chk("or_valid3", 32'(b1.rsp_valid), 32'h1);
    chk("or_data3", b1.rsp_rdata, 32'hCAFEF00D);
    idle();
    chk("or_valid4", 32'(b1.rsp_valid), 32'h1);
    chk("or_data4", b1.rsp_rdata, 32'h000080AD);
    idle();
    chk("or_drain", 32'(b1.rsp_valid), 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    reset = 1'b0;
    #1;
    chk("mrst_valid1", 32'(b1.rsp_valid), 32'h0);
    chk("mrst_valid0", 32'(b0.rsp_valid), 32'h0);
    chk("mrst_rdata0", b0.rsp_rdata, 32'h0);
    chk("mrst_err0", 32'(b0.rsp_err), 32'h0);
    chk("mrst_acc0", 32'(ac0), 32'h0);
    chk("mrst_acc1", 32'(ac1), 32'h0);
    chk("mrst_sticky1", 32'(es1), 32'h0);
    idle();
    chk("mrst_hold_valid1", 32'(b1.rsp_valid), 32'h0);
    reset = 1'b1;
    idle();
    chk("post_rst_valid1", 32'(b1.rsp_valid), 32'h0);
    idle();
    chk("post_rst_valid1b", 32'(b1.rsp_valid), 32'h0);
    chk("post_rst_acc0", 32'(ac0), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised data-memory controller for the single-cycle/pipelined core.
- Replaces the fixed 1024x32 word-addressed store.
- Byte-addressed; supports byte, half and word loads/stores with byte enables and load sign/zero extension.
- Every accepted request returns exactly one response after a fixed latency.
- Misaligned and out-of-range accesses are detected.
- Sits between the ALU address output and the writeback mux.

Parameters:
DATA_W, 32, data width in bits; multiple of 8, minimum 16
DEPTH, 1024, memory depth in words; power of 2
ADDR_W, 32, width of the incoming byte address
OUT_REG, 0, 1 adds an output register stage (response latency 1+OUT_REG)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  1  request present this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_W  byte address (ALU result)
req_wdata  in  DATA_W  store data, right-aligned (rtOut)
rsp_valid  out  1  response strobe
rsp_rdata  out  DATA_W  load result, extended; 0 for stores and errors
rsp_err  out  1  with rsp_valid: request was misaligned, out of range or reserved size
err_sticky  out  1  set on any error response; cleared only by clr_err or reset
clr_err  in  1  synchronous clear of err_sticky
acc_count  out  16  number of accepted requests, wraps at 0xFFFF

Behaviour:
Reset (reset=0, async)
- rsp_valid=0, rsp_rdata=0, rsp_err=0, err_sticky=0, acc_count=0.
- All pipeline valid bits cleared; memory contents undefined.
- A reset mid-flight drops the in-flight response.

Acceptance
- No ready signal: one request is accepted per cycle whenever req_valid=1.
- Back-to-back requests are fully pipelined.

Addressing
- B = DATA_W/8; lane = req_addr[log2(B)-1:0]; word index = req_addr >> log2(B).
- Out of range: word index >= DEPTH.

Error checks (at acceptance)
- misaligned: half with lane[0]≠0, or word with lane≠0.
- reserved: size=11.
- Any error: no memory write; the response carries rsp_err=1 and rsp_rdata=0.

Stores
- Written on the accept edge using the byte-enable mask:
  - byte: 1<<lane
  - half: 3<<lane
  - word: all ones
- Data replicated across lanes before masking.
- Unmasked bytes are preserved.
- Response carries rsp_rdata=0, rsp_err as computed.

Loads
- Synchronous memory read, registered with size, lane and unsigned flag.
- Extraction: shift right by lane*8, take 8/16/DATA_W bits.
- Extension: sign bit from the top of the field unless req_unsigned=1.

Latency
- rsp_valid asserts exactly 1+OUT_REG cycles after acceptance, for one cycle per request.
- Responses are returned in order.

Hazards
- A load to the same word in the cycle after a store must return the new data (write-first).
- The bench checks this case; implement forwarding if the memory primitive is read-first.

err_sticky
- Set on the cycle an error response is issued.
- If clr_err and a new error response occur in the same cycle, set wins.

acc_count
- Increments on each accepted request, including erroring ones.

Debug
- $display on each store, simulation-only under `ifndef SYNTHESIS.

Test Plan:
1. Word store 0xDEADBEEF @0x10, load word @0x10 next cycle (OUT_REG=0) -> rsp_valid one cycle after the load; rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Byte store 0x80 @0x13, then signed byte load @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word load @0x10 -> 0x80ADBEEF.
3. Half load @0x11 -> rsp_err=1, rsp_rdata=0, err_sticky=1. Word store @0x12 -> no memory change; word @0x10 still reads 0x80ADBEEF. Pulse clr_err -> err_sticky=0.
4. Word load @0x1000 with DEPTH=1024 -> rsp_err=1. size=11 -> rsp_err=1. acc_count counts both.
5. OUT_REG=1: 4 back-to-back loads -> 4 consecutive rsp_valid pulses, each exactly 2 cycles after its request, in order.
6. Drive reset low with a load in flight -> rsp_valid never asserts for it; all outputs and acc_count read 0 while reset is low.
